// File: rtl/pmem_line_adapter.sv
// Serves one cache-line pmem read or writeback as a burst of word beats on the narrow memory bus.
// Build macro PMEM_LINE_ADAPTER_CRITICAL_WORD_FIRST_EN: read bursts start at the requested word and wrap.
module pmem_line_adapter #(
  parameter int unsigned LINE_WIDTH = 128,
  parameter int unsigned WORD_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  pmem_read,
  input  logic                  pmem_write,
  input  logic [15:0]           pmem_address,
  input  logic [LINE_WIDTH-1:0] pmem_wdata,
  output logic [LINE_WIDTH-1:0] pmem_rdata,
  output logic                  pmem_resp,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [15:0]           mem_address,
  output logic [WORD_WIDTH-1:0] mem_wdata,
  input  logic [WORD_WIDTH-1:0] mem_rdata,
  input  logic                  mem_resp
);
  localparam int unsigned ADDRW = 16;
  localparam int unsigned BEATS = LINE_WIDTH / WORD_WIDTH;
  localparam int unsigned IDXW  = $clog2(BEATS);
  localparam int unsigned TAGW  = ADDRW - IDXW - 1;
  localparam int unsigned LWW   = $clog2(LINE_WIDTH);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2,
    DONE     = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [IDXW-1:0]       beat_q, beat_d;
  logic [IDXW-1:0]       cnt_q, cnt_d;
  logic [LINE_WIDTH-1:0] line_q, line_d;
  logic [LINE_WIDTH-1:0] rdata_q, rdata_d;
  logic                  resp_q, resp_d;
  logic                  rd_q, rd_d;
  logic                  wr_q, wr_d;
  logic [ADDRW-1:0]      addr_q, addr_d;
  logic [WORD_WIDTH-1:0] wdata_q, wdata_d;

  logic [IDXW-1:0]       rd_start;
  logic [IDXW-1:0]       beat_nxt;
  logic [TAGW-1:0]       req_tag;
  logic [TAGW-1:0]       cur_tag;
  logic [LWW-1:0]        slot;
  logic [LWW-1:0]        slot_nxt;
  logic                  beat_fire;
  logic                  last_beat;
  logic                  unused_addr_bits;

  // Start beat of a read burst: requested word when critical-word-first is built in.
`ifdef PMEM_LINE_ADAPTER_CRITICAL_WORD_FIRST_EN
  assign rd_start = pmem_address[IDXW:1];
`else
  assign rd_start = '0;
`endif

  assign unused_addr_bits = ^pmem_address[IDXW:0];
  assign req_tag   = pmem_address[ADDRW-1 -: TAGW];
  assign cur_tag   = addr_q[ADDRW-1 -: TAGW];
  assign beat_nxt  = beat_q + IDXW'(1);
  assign slot      = LWW'(beat_q) * LWW'(WORD_WIDTH);
  assign slot_nxt  = LWW'(beat_nxt) * LWW'(WORD_WIDTH);
  assign beat_fire = mem_resp && ((state_q == RD_BURST) || (state_q == WR_BURST));
  // Burst ends on the beats-done count, independent of where the beat index started.
  assign last_beat = beat_fire && (cnt_q == IDXW'(BEATS - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      beat_q  <= '0;
      cnt_q   <= '0;
      line_q  <= '0;
      rdata_q <= '0;
      resp_q  <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
      rdata_q <= rdata_d;
      resp_q  <= resp_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Next state; a simultaneous write and read accepts the write first.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (pmem_write) begin
          state_d = WR_BURST;
        end else if (pmem_read) begin
          state_d = RD_BURST;
        end
      end
      RD_BURST, WR_BURST: begin
        if (last_beat) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs and datapath; bus fields only move on an accepted beat.
  always_comb begin
    beat_d  = beat_q;
    cnt_d   = cnt_q;
    line_d  = line_q;
    rdata_d = rdata_q;
    resp_d  = 1'b0;
    rd_d    = rd_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        rd_d = 1'b0;
        wr_d = 1'b0;
        if (pmem_write) begin
          line_d  = pmem_wdata;
          beat_d  = '0;
          cnt_d   = '0;
          wr_d    = 1'b1;
          addr_d  = {req_tag, IDXW'(0), 1'b0};
          wdata_d = pmem_wdata[WORD_WIDTH-1:0];
        end else if (pmem_read) begin
          beat_d = rd_start;
          cnt_d  = '0;
          rd_d   = 1'b1;
          addr_d = {req_tag, rd_start, 1'b0};
        end
      end
      RD_BURST: begin
        if (beat_fire) begin
          line_d[slot +: WORD_WIDTH] = mem_rdata;
          beat_d = beat_nxt;
          cnt_d  = cnt_q + IDXW'(1);
          if (last_beat) begin
            rd_d    = 1'b0;
            resp_d  = 1'b1;
            rdata_d = line_d;
          end else begin
            addr_d = {cur_tag, beat_nxt, 1'b0};
          end
        end
      end
      WR_BURST: begin
        if (beat_fire) begin
          beat_d = beat_nxt;
          cnt_d  = cnt_q + IDXW'(1);
          if (last_beat) begin
            wr_d   = 1'b0;
            resp_d = 1'b1;
          end else begin
            addr_d  = {cur_tag, beat_nxt, 1'b0};
            wdata_d = line_q[slot_nxt +: WORD_WIDTH];
          end
        end
      end
      DONE: begin
        rd_d = 1'b0;
        wr_d = 1'b0;
      end
      default: begin
        rd_d = 1'b0;
        wr_d = 1'b0;
      end
    endcase
  end

  assign pmem_rdata  = rdata_q;
  assign pmem_resp   = resp_q;
  assign mem_read    = rd_q;
  assign mem_write   = wr_q;
  assign mem_address = addr_q;
  assign mem_wdata   = wdata_q;

endmodule

// File: tb/tb_pmem_line_adapter.sv
// Scoreboard bench for pmem_line_adapter: a line-level model predicts beats and pmem_rdata,
// and a memory-side monitor/responder pops and compares as the DUT presents beats and responses.
module tb_pmem_line_adapter;
  localparam int unsigned LW    = 128;
  localparam int unsigned WW    = 16;
  localparam int unsigned BEATS = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          pmem_read = 1'b0;
  logic          pmem_write = 1'b0;
  logic [15:0]   pmem_address = '0;
  logic [LW-1:0] pmem_wdata = '0;
  logic [LW-1:0] pmem_rdata;
  logic          pmem_resp;
  logic          mem_read;
  logic          mem_write;
  logic [15:0]   mem_address;
  logic [WW-1:0] mem_wdata;
  logic [WW-1:0] mem_rdata = '0;
  logic          mem_resp = 1'b0;

  pmem_line_adapter #(.LINE_WIDTH(LW), .WORD_WIDTH(WW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_address  (mem_address),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_resp     (mem_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [15:0] data;
  } beat_t;

  beat_t         beat_sb[$];
  logic [LW-1:0] resp_sb[$];
  logic [15:0]   phys_mem [32768];
  logic [15:0]   ref_mem  [32768];
  logic [LW-1:0] last_rd_line = '0;
  int            checks = 0;
  int            failures = 0;
  int            mode = 0;
  int            req_beats = 0;
  int            cyc = 0;

  function automatic void chk(string name, logic [LW-1:0] act, logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Line-level model: beat order, beat contents, and the line the cache should see.
  function automatic void push_req(bit wr, logic [15:0] a, logic [LW-1:0] wd);
    int start;
    int b;
    beat_t e;
    logic [LW-1:0] line;
    start = 0;
`ifdef PMEM_LINE_ADAPTER_CRITICAL_WORD_FIRST_EN
    if (!wr) start = int'(a[3:1]);
`endif
    for (int k = 0; k < int'(BEATS); k++) begin
      b = (start + k) % int'(BEATS);
      e.wr   = wr;
      e.addr = {a[15:4], 3'(b), 1'b0};
      e.data = wr ? wd[16*b +: 16] : 16'h0;
      beat_sb.push_back(e);
      if (wr) ref_mem[{a[15:4], 3'(b)}] = wd[16*b +: 16];
    end
    if (!wr) begin
      for (int j = 0; j < int'(BEATS); j++) line[16*j +: 16] = ref_mem[{a[15:4], 3'(j)}];
      last_rd_line = line;
    end
    resp_sb.push_back(last_rd_line);
  endfunction

  // Memory responder and monitor.
  logic          prev_strobe = 1'b0;
  logic          prev_go = 1'b0;
  logic          prev_resp = 1'b0;
  logic [15:0]   prev_addr = '0;
  logic [15:0]   prev_wdata = '0;

  always @(negedge clk) begin
    logic go;
    logic strobe;
    beat_t e;
    cyc++;
    if (!reset_n) begin
      mem_resp    = 1'b0;
      prev_strobe = 1'b0;
      prev_go     = 1'b0;
      prev_resp   = 1'b0;
      req_beats   = 0;
    end else begin
      strobe = mem_read | mem_write;
      if (strobe) chk("strobe_exclusive", LW'(mem_read & mem_write), '0);
      if (strobe && prev_strobe && !prev_go) begin
        chk("addr_stable", LW'(mem_address), LW'(prev_addr));
        if (mem_write) chk("wdata_stable", LW'(mem_wdata), LW'(prev_wdata));
      end
      if (pmem_resp) begin
        chk("resp_single_cycle", LW'(prev_resp), '0);
        chk("done_no_strobe", LW'(strobe), '0);
        if (resp_sb.size() == 0) begin
          chk("unexpected_resp", LW'(1), '0);
        end else begin
          chk("pmem_rdata", pmem_rdata, resp_sb.pop_front());
          chk("beats_per_line", LW'(req_beats), LW'(BEATS));
        end
        req_beats = 0;
      end
      case (mode)
        0:       go = 1'b1;
        1:       go = (cyc % 3 == 0);
        default: go = 1'($urandom_range(0, 1));
      endcase
      go = go & strobe;
      if (go) begin
        mem_resp = 1'b1;
        if (beat_sb.size() == 0) begin
          chk("unexpected_beat", LW'(mem_address), '1);
        end else begin
          e = beat_sb.pop_front();
          chk("beat_kind", LW'(mem_write), LW'(e.wr));
          chk("beat_addr", LW'(mem_address), LW'(e.addr));
          if (e.wr) chk("beat_wdata", LW'(mem_wdata), LW'(e.data));
        end
        if (mem_write) phys_mem[mem_address[15:1]] = mem_wdata;
        else mem_rdata = phys_mem[mem_address[15:1]];
        req_beats++;
      end else begin
        mem_resp  = 1'b0;
        mem_rdata = 16'($urandom);
      end
      prev_strobe = strobe;
      prev_go     = go;
      prev_resp   = pmem_resp;
      prev_addr   = mem_address;
      prev_wdata  = mem_wdata;
    end
  end

  task automatic wait_resp(output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!pmem_resp && k < 400);
    if (!pmem_resp) chk("resp_timeout", '0, LW'(1));
  endtask

  // Issues one cache request (read, write or both) from a negedge and waits for completion.
  task automatic run_req(bit rd, bit wr, logic [15:0] a, logic [LW-1:0] wd, int m);
    int k;
    mode = m;
    if (wr) push_req(1'b1, a, wd);
    if (rd) push_req(1'b0, a, wd);
    pmem_address = a;
    pmem_wdata   = wd;
    pmem_read    = rd;
    pmem_write   = wr;
    wait_resp(k);
    if (rd && wr) begin
      pmem_write = 1'b0;
      wait_resp(k);
    end else if (m == 0) begin
      chk("latency", LW'(k), LW'(9));
    end
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
  endtask

  localparam logic [LW-1:0] FILL_LINE = 128'h7777_6666_5555_4444_3333_2222_1111_0000;

  initial begin
    logic [15:0] lines [4];
    logic [15:0] a;
    int          r;
    int          k;
    logic        saw;
    lines[0] = 16'h1230; lines[1] = 16'h4560; lines[2] = 16'h0880; lines[3] = 16'hFFF0;
    for (int i = 0; i < 32768; i++) begin
      phys_mem[i] = 16'($urandom);
      ref_mem[i]  = phys_mem[i];
    end
    for (int j = 0; j < int'(BEATS); j++) begin
      phys_mem[{12'h123, 3'(j)}] = 16'(j * 16'h1111);
      ref_mem[{12'h123, 3'(j)}]  = 16'(j * 16'h1111);
    end

    #12;
    chk("rst_pmem_resp", LW'(pmem_resp), '0);
    chk("rst_mem_read", LW'(mem_read), '0);
    chk("rst_mem_write", LW'(mem_write), '0);
    chk("rst_mem_address", LW'(mem_address), '0);
    chk("rst_mem_wdata", LW'(mem_wdata), '0);
    chk("rst_pmem_rdata", pmem_rdata, '0);
    @(negedge clk);
    reset_n = 1'b1;

    @(negedge clk);
    run_req(1'b1, 1'b0, 16'h1230, '0, 0);
    chk("fill_line", pmem_rdata, FILL_LINE);

    @(negedge clk);
    run_req(1'b0, 1'b1, 16'h4560, 128'h0123456789ABCDEF_FEDCBA9876543210, 0);
    chk("rdata_held_over_write", pmem_rdata, FILL_LINE);

    @(negedge clk);
    run_req(1'b1, 1'b0, 16'h4560, '0, 1);
    chk("readback_after_wait", pmem_rdata, 128'h0123456789ABCDEF_FEDCBA9876543210);

    @(negedge clk);
    run_req(1'b1, 1'b1, 16'h0880, {4{32'($urandom)}}, 2);

    @(negedge clk);
    run_req(1'b1, 1'b0, 16'h123A, '0, 0);
    chk("cwf_line", pmem_rdata, FILL_LINE);

    // Reset in the middle of a read burst.
    @(negedge clk);
    mode = 0;
    push_req(1'b0, 16'h1230, '0);
    pmem_address = 16'h1230;
    pmem_read    = 1'b1;
    k = 0;
    while (req_beats < 4 && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("abort_reached_beat4", LW'(req_beats >= 4), LW'(1));
    #2 reset_n = 1'b0;
    #1;
    chk("abort_mem_read", LW'(mem_read), '0);
    chk("abort_mem_write", LW'(mem_write), '0);
    chk("abort_pmem_resp", LW'(pmem_resp), '0);
    chk("abort_pmem_rdata", pmem_rdata, '0);
    pmem_read = 1'b0;
    beat_sb.delete();
    resp_sb.delete();
    last_rd_line = '0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      saw = saw | pmem_resp | mem_read | mem_write;
    end
    chk("abort_quiet", LW'(saw), '0);
    chk("abort_rdata_cleared", pmem_rdata, '0);

    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 2);
      for (int i = 0; i <= r; i++) @(negedge clk);
      a = lines[$urandom_range(0, 3)] | 16'($urandom_range(0, 15));
      r = $urandom_range(0, 9);
      run_req(r < 4 || r >= 8, r >= 4, a, {32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)},
              $urandom_range(0, 2));
    end

    repeat (4) @(negedge clk);
    chk("beats_drained", LW'(beat_sb.size()), '0);
    chk("resps_drained", LW'(resp_sb.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
